// File: rtl/wm_pkg.sv
// Shared encodings for the washing-machine controller and its plant model.
package wm_pkg;

  typedef enum logic [2:0] {
    M_IDLE,
    M_AGITATE,
    M_SPIN,
    M_HOLD_A,
    M_HOLD_S
  } motor_state_e;

  typedef enum logic [2:0] {
    C_IDLE,
    C_LOCK,
    C_FILL,
    C_SOAP,
    C_WASH,
    C_DRAIN,
    C_SPIN,
    C_DONE
  } ctrl_state_e;

endpackage

// File: rtl/wm_tick_timer.sv
// Enable/clear tick counter with a runtime terminal count and a held done flag.
module wm_tick_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic         hit,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;

  // hit fires on the enabled cycle that reaches the terminal count
  assign hit  = en && !done_q && (cnt_q == last);
  assign done = done_q;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (hit) begin
      done_d = 1'b1;
    end else if (en && !done_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/wm_plant_model.sv
// Behavioural washing-machine plant: water level, motor timers, dispenser and door.
module wm_plant_model
  import wm_pkg::*;
#(
  parameter  int unsigned MAX_LEVEL   = 16,
  parameter  int unsigned FILL_RATE   = 1,
  parameter  int unsigned DRAIN_RATE  = 2,
  parameter  int unsigned CYCLE_TICKS = 20,
  parameter  int unsigned SPIN_TICKS  = 10,
  parameter  int unsigned DET_TICKS   = 4,
  parameter  int unsigned TMR_W       = 16,
  localparam int unsigned LVL_W       = $clog2(MAX_LEVEL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_valve_on,
  input  logic             drain_valve_on,
  input  logic             motor_on,
  input  logic             door_lock,
  input  logic             soap_wash,
  input  logic             door_open_req,
  input  logic             door_close_req,
  output logic             filled,
  output logic             drained,
  output logic             cycle_time_out,
  output logic             spin_time_out,
  output logic             detergent_added,
  output logic             door_close,
  output logic [LVL_W-1:0] water_level,
  output logic             overflow_err,
  output logic             door_err
);

  localparam int unsigned SW = LVL_W + 2;
  localparam logic signed [SW-1:0]    FILL_S  = SW'(FILL_RATE);
  localparam logic signed [SW-1:0]    DRAIN_S = SW'(DRAIN_RATE);
  localparam logic signed [SW-1:0]    MAX_S   = SW'(MAX_LEVEL);
  localparam logic [LVL_W-1:0]        LVL_MAX = LVL_W'(MAX_LEVEL);
  localparam logic [TMR_W-1:0]        AG_LAST = TMR_W'(CYCLE_TICKS - 1);
  localparam logic [TMR_W-1:0]        SP_LAST = TMR_W'(SPIN_TICKS - 1);
  localparam logic [TMR_W-1:0]        DT_LAST = TMR_W'(DET_TICKS - 1);

  motor_state_e      state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic signed [SW-1:0] lvl_sum;
  logic              overflow_err_q, overflow_err_d;
  logic              door_close_q, door_close_d;
  logic              door_err_q, door_err_d;
  logic              mot_en, mot_clr, mot_hit, mot_done;
  logic [TMR_W-1:0]  mot_last;
  logic              det_en, det_hit_unused, det_done;

  assign filled          = (level_q == LVL_MAX);
  assign drained         = (level_q == '0);
  assign water_level     = level_q;
  assign overflow_err    = overflow_err_q;
  assign door_close      = door_close_q;
  assign door_err        = door_err_q;
  assign detergent_added = det_done;
  assign cycle_time_out  = mot_done && (state_q == M_HOLD_A);
  assign spin_time_out   = mot_done && (state_q == M_HOLD_S);

  // Level arithmetic is signed two bits wider so underflow shows up as a negative sum.
  always_comb begin
    lvl_sum = signed'({2'b00, level_q});
    if (fill_valve_on)  lvl_sum = lvl_sum + FILL_S;
    if (drain_valve_on) lvl_sum = lvl_sum - DRAIN_S;
    if (lvl_sum[SW-1])       level_d = '0;
    else if (lvl_sum > MAX_S) level_d = LVL_MAX;
    else                      level_d = lvl_sum[LVL_W-1:0];
  end

  always_comb begin
    overflow_err_d = overflow_err_q | (fill_valve_on && (level_q == LVL_MAX));
    door_close_d   = door_close_q;
    if (door_close_req)                                door_close_d = 1'b1;
    else if (door_open_req && !door_lock && !motor_on) door_close_d = 1'b0;
    door_err_d     = door_err_q | (!door_close_q && (door_lock || motor_on));
  end

  // Mode is chosen once at motor start; the timer clears in IDLE or when the motor stops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      M_IDLE:    if (motor_on) state_d = (level_q == '0) ? M_SPIN : M_AGITATE;
      M_AGITATE: if (!motor_on) state_d = M_IDLE; else if (mot_hit) state_d = M_HOLD_A;
      M_SPIN:    if (!motor_on) state_d = M_IDLE; else if (mot_hit) state_d = M_HOLD_S;
      M_HOLD_A,
      M_HOLD_S:  if (!motor_on) state_d = M_IDLE;
      default:   state_d = M_IDLE;
    endcase
  end

  assign mot_en   = motor_on && ((state_q == M_AGITATE) || (state_q == M_SPIN));
  assign mot_clr  = (state_q == M_IDLE) || !motor_on;
  assign mot_last = (state_q == M_SPIN) ? SP_LAST : AG_LAST;
  assign det_en   = soap_wash && filled && !motor_on;

  wm_tick_timer #(.W(TMR_W)) u_motor_tmr (
    .clk  (clk),
    .rst  (rst),
    .en   (mot_en),
    .clr  (mot_clr),
    .last (mot_last),
    .hit  (mot_hit),
    .done (mot_done)
  );

  wm_tick_timer #(.W(TMR_W)) u_det_tmr (
    .clk  (clk),
    .rst  (rst),
    .en   (det_en),
    .clr  (!soap_wash),
    .last (DT_LAST),
    .hit  (det_hit_unused),
    .done (det_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= M_IDLE;
      level_q        <= '0;
      overflow_err_q <= 1'b0;
      door_close_q   <= 1'b1;
      door_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      overflow_err_q <= overflow_err_d;
      door_close_q   <= door_close_d;
      door_err_q     <= door_err_d;
    end
  end

endmodule

// File: doc/wm_plant_model.md
Name: wm_plant_model

Overview:
- Behavioural appliance model driven by the wash controller's actuator outputs; it generates that controller's sensor inputs.
- Models water level, motor agitate/spin timers, detergent dispenser and door, with sticky fault flags for misuse.
- Provides the closed loop for system simulation and FPGA demo builds; user-side door requests come from the bench or top-level switches.

Parameters:
- MAX_LEVEL, 16, level units at which the tub is full; LVL_W = $clog2(MAX_LEVEL+1).
- FILL_RATE, 1, units added per cycle while fill valve open.
- DRAIN_RATE, 2, units removed per cycle while drain valve open.
- CYCLE_TICKS, 20, agitate cycles before cycle_time_out; must be >= 1.
- SPIN_TICKS, 10, spin cycles before spin_time_out; must be >= 1.
- DET_TICKS, 4, dispense cycles before detergent_added; must be >= 1.
- TMR_W, 16, timer width; every *_TICKS must be < 2^TMR_W.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge when 0).
- fill_valve_on  in  1  actuator command from the controller.
- drain_valve_on  in  1  actuator command from the controller.
- motor_on  in  1  actuator command from the controller.
- door_lock  in  1  actuator command from the controller.
- soap_wash  in  1  dispense request from the controller.
- door_open_req  in  1  user request to open the door.
- door_close_req  in  1  user request to close the door.
- filled  out  1  level == MAX_LEVEL.
- drained  out  1  level == 0.
- cycle_time_out  out  1  agitate timer expired; held.
- spin_time_out  out  1  spin timer expired; held.
- detergent_added  out  1  dispense complete; held.
- door_close  out  1  door is closed.
- water_level  out  LVL_W  current level, for debug/display.
- overflow_err  out  1  sticky: fill commanded while full.
- door_err  out  1  sticky: door open while door_lock or motor_on.

Behaviour:
- Reset (rst=0 at edge): level=0, motor FSM IDLE, timers=0, det counter=0, door closed, errors cleared. Resulting outputs: drained=1, filled=0, door_close=1, all other outputs 0.
- filled/drained are combinational decodes of the level register. All other outputs are registered. Sensor response to an actuator change appears one cycle later.
- Level update each cycle:
  - next = level + (fill ? FILL_RATE : 0) - (drain ? DRAIN_RATE : 0), computed signed at LVL_W+2 bits.
  - Result is clamped to [0, MAX_LEVEL].
  - Fill and drain together apply the net value.
- overflow_err is set when fill_valve_on=1 and level==MAX_LEVEL. It stays set until reset.
- Motor FSM states: IDLE, AGITATE, SPIN, HOLD_A, HOLD_S.
  - IDLE: if motor_on and level==0, go to SPIN; if motor_on and level!=0, go to AGITATE. Timer is cleared on entry to either state.
  - AGITATE: timer increments each cycle. If motor_on=0, go to IDLE. If timer==CYCLE_TICKS-1, go to HOLD_A and set cycle_time_out=1.
  - SPIN: same as AGITATE with SPIN_TICKS; exits to HOLD_S and sets spin_time_out=1.
  - HOLD_A/HOLD_S: the timeout stays 1 while motor_on=1. If motor_on=0, go to IDLE and clear both timeouts in the same edge.
  - The mode (agitate or spin) is latched at motor start. Later level changes do not switch it.
  - Total latency: motor_on rising to timeout high is CYCLE_TICKS+1 edges for agitate, SPIN_TICKS+1 for spin.
- Detergent:
  - Counter increments while soap_wash && filled && !motor_on && !detergent_added.
  - At count==DET_TICKS-1, detergent_added=1, held.
  - soap_wash=0 clears both the counter and detergent_added next edge.
  - Losing filled mid-count freezes the counter; it does not clear it.
- Door:
  - door_open_req while door_lock=0 and motor_on=0: door opens next edge.
  - door_close_req: door closes next edge.
  - If both requests are high, close wins.
  - An open request under lock is ignored.
  - door_err is set if the door is open while door_lock or motor_on is 1. It is sticky.
- Reset mid-operation returns all state to reset values regardless of inputs.

Decomposition:
- Shared package wm_pkg holds the motor FSM state encodings. The controller's state encodings move there as well.
- One sub-module, wm_tick_timer (enable, clear, terminal count, held done flag), is instantiated twice: agitate/spin and detergent.

Test Plan:
- Reset, then fill_valve_on=1 with defaults -> filled rises after 16 edges (water_level=16). Holding fill one more edge sets overflow_err=1, which persists after fill drops.
- Level 16, drain_valve_on=1 -> level 14,12,…,0; drained=1 after 8 edges. Fill+drain together at level 5 -> level decreases by 1 per edge.
- Level 16, motor_on=1 -> cycle_time_out=1 on edge 21 and held. motor_on=0 -> cleared next edge. Repeat at level 0 -> spin_time_out on edge 11.
- Level 16, soap_wash=1 -> detergent_added=1 after 4 edges. soap_wash=0 -> 0 next edge. Toggling motor_on mid-count pauses the counter.
- door_lock=1, door_open_req=1 -> door_close stays 1. After unlock -> door_close=0 next edge. Then door_lock=1 -> door_err=1.
- Assert rst=0 during AGITATE at timer=10 -> next edge all outputs at reset values, drained=1, door_close=1.
